// File: rtl/bp_nonsynth_stall_hist_reader.sv
// Stall-attribution histogram: per-reason, instret and record saturating counters
// exposed through a single-outstanding valid/ready read port.
module bp_nonsynth_stall_hist_reader #(
    parameter int num_reasons_p   = 24,
    parameter int counter_width_p = 32,
    parameter int addr_width_p    = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       freeze_i,
    input  logic                       clear_i,
    input  logic                       event_v_i,
    input  logic                       event_instret_i,
    input  logic [4:0]                 event_reason_i,
    input  logic                       req_v_i,
    output logic                       req_ready_o,
    input  logic [addr_width_p-1:0]    req_addr_i,
    output logic                       resp_v_o,
    output logic [counter_width_p-1:0] resp_data_o,
    output logic                       resp_err_o,
    input  logic                       resp_yumi_i
);

    localparam int num_ctrs_lp    = num_reasons_p + 2;
    localparam int instret_idx_lp = num_reasons_p;
    localparam int record_idx_lp  = num_reasons_p + 1;

    logic                       accept_s;
    logic                       fire_s;
    logic [num_ctrs_lp-1:0]     inc_s;
    logic [counter_width_p-1:0] rd_data_s;
    logic                       rd_err_s;

    logic [counter_width_p-1:0] ctr_r [num_ctrs_lp];
    logic                       resp_v_r;
    logic [counter_width_p-1:0] resp_data_r;
    logic                       resp_err_r;

    assign accept_s    = event_v_i & ~freeze_i & ~clear_i;
    assign req_ready_o = ~resp_v_r | resp_yumi_i;
    assign fire_s      = req_v_i & req_ready_o;

    assign resp_v_o    = resp_v_r;
    assign resp_data_o = resp_data_r;
    assign resp_err_o  = resp_err_r;

    // Decode an accepted record into increment strobes; out-of-range reasons fold onto code 0
    always_comb begin
        inc_s = '0;
        if (accept_s) begin
            inc_s[record_idx_lp] = 1'b1;
            if (event_instret_i) begin
                inc_s[instret_idx_lp] = 1'b1;
            end else if (32'(event_reason_i) < 32'(num_reasons_p)) begin
                inc_s[event_reason_i] = 1'b1;
            end else begin
                inc_s[0] = 1'b1;
            end
        end else begin
            inc_s = '0;
        end
    end

    // Counter array: clear dominates, increments stop at all-ones
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_ctrs_lp; i++) begin
                ctr_r[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < num_ctrs_lp; i++) begin
                ctr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_ctrs_lp; i++) begin
                if (inc_s[i] && (ctr_r[i] != {counter_width_p{1'b1}})) begin
                    ctr_r[i] <= ctr_r[i] + counter_width_p'(1'b1);
                end
            end
        end
    end

    // Read mux sees the pre-update counter values
    always_comb begin
        rd_data_s = '0;
        rd_err_s  = 1'b0;
        if (32'(req_addr_i) < 32'(num_ctrs_lp)) begin
            rd_data_s = ctr_r[req_addr_i];
            rd_err_s  = 1'b0;
        end else begin
            rd_data_s = '0;
            rd_err_s  = 1'b1;
        end
    end

    // Response register: captured on fire, held until yumi
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_v_r    <= 1'b0;
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
        end else if (fire_s) begin
            resp_v_r    <= 1'b1;
            resp_data_r <= rd_data_s;
            resp_err_r  <= rd_err_s;
        end else if (resp_yumi_i) begin
            resp_v_r    <= 1'b0;
        end else begin
            resp_v_r    <= resp_v_r;
        end
    end

endmodule

// File: doc/bp_nonsynth_stall_hist_reader.md
Name: bp_nonsynth_stall_hist_reader

Overview:
- Consumer end of the core stall-attribution stream. Each cycle the profiler emits one record: either "instr" (an instruction retired) or a 5-bit stall-reason code 0..23.
- This block accumulates those records into per-reason saturating counters, plus retired-instruction and total-record counters.
- It exposes all counters through a single-outstanding valid/ready read port, so benches and debug logic can read the histogram live instead of parsing the trace file.
- It sits beside the core profiler in the per-core testbench harness.

Parameters:
- num_reasons_p, 24, number of stall-reason codes; valid codes are 0..num_reasons_p-1.
- counter_width_p, 32, width of every counter and of the read data.
- addr_width_p, 5, read address width; must satisfy 2**addr_width_p >= num_reasons_p+2.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- freeze_i  in  1  when high, records are ignored; reads still work.
- clear_i  in  1  synchronous clear of all counters.
- event_v_i  in  1  a record is present this cycle.
- event_instret_i  in  1  record is a retired instruction.
- event_reason_i  in  5  stall-reason code; ignored when event_instret_i=1.
- req_v_i  in  1  read request valid.
- req_ready_o  out  1  block can accept a request.
- req_addr_i  in  addr_width_p  counter index.
- resp_v_o  out  1  response valid.
- resp_data_o  out  counter_width_p  counter value.
- resp_err_o  out  1  address out of range.
- resp_yumi_i  in  1  consumer takes the response; legal only when resp_v_o=1.

Behaviour:
- Address map:
  - 0..num_reasons_p-1: stall counters.
  - num_reasons_p: instret counter.
  - num_reasons_p+1: record counter (total accepted records).
  - Any higher address: resp_data_o=0 and resp_err_o=1.
- Reset (reset_n_i=0, asynchronous): all counters=0, resp_v_o=0, resp_data_o=0, resp_err_o=0, req_ready_o=1 as soon as reset deasserts.
- A record is accepted when event_v_i & ~freeze_i & ~clear_i. On accept:
  - The record counter increments.
  - If event_instret_i=1, the instret counter increments.
  - Otherwise counter[event_reason_i] increments.
  - A reason >= num_reasons_p is treated as code 0 (unknown).
- Counters saturate at 2**counter_width_p-1; they never wrap.
- clear_i has priority over a same-cycle accept: all counters are 0 on the next cycle and the record is dropped.
- Read handshake:
  - req_ready_o = ~resp_v_o | resp_yumi_i.
  - A request fires when req_v_i & req_ready_o.
  - The response is registered, so resp_v_o=1 on the cycle after the request fires.
  - resp_data_o and resp_err_o hold stable while resp_v_o=1 and resp_yumi_i=0.
  - Back-to-back reads: a new request may fire in the same cycle as resp_yumi_i, giving one response per cycle with no bubble.
- Read/update collisions:
  - The response carries the counter value sampled before the same-cycle update.
  - A read fired in the same cycle as clear_i returns the pre-clear value.
- A response that has been captured keeps its value even if the counter later changes or is cleared.
- freeze_i affects only recording; the read path is unaffected.
- Asserting reset_n_i mid-transaction drops any pending response (resp_v_o=0 immediately) and zeroes all counters.
- Implementation:
  - Flop array of num_reasons_p+2 counters.
  - Read mux plus a response register.
  - Response-valid flop.
  - No other state.

Test Plan:
- Reset, then 10 records with reason 6, 3 with reason 13, 5 instret; read addrs 6, 13, 24, 25 -> 10, 3, 5, 18; every other stall address returns 0.
- Reason code 30 sent 4 times -> counter 0 reads 4; a read at addr 31 -> data 0, err 1.
- counter_width_p=4: 20 records with reason 2 -> reads 15 (saturated); the record counter also reads 15.
- Read of addr 6 issued in the same cycle as a reason-6 record, with the count at 7 -> response 7; a following read returns 8. clear_i together with a record -> every address reads 0.
- Hold resp_yumi_i=0 for 5 cycles -> resp_v_o and resp_data_o stable, req_ready_o=0. Then 8 consecutive requests with resp_yumi_i held at 1 -> 8 responses in 8 consecutive cycles.
- freeze_i=1 for 6 records -> counters unchanged, reads still respond. Drop reset_n_i mid-cycle with resp_v_o=1 -> resp_v_o falls without waiting for a clock edge and all counters read 0 after reset.
